// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: Gray/binary conversion
// and depth derivation from the address width.
package fifo_pkg;

  // Number of RAM slots for a given address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Binary to reflected Gray code; upper unused bits stay zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary for a pointer of the given width; bits above width are ignored.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] g;
    logic [31:0] bin;
    g   = '0;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) g[i] = gray[i];
    end
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(g >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Pure flop chain: no logic between stages so only one bit can be in flight.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             W_CLK,
  input  logic             W_RST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the foreign pointer through STAGES flops; cleared on reset.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO. Keeps the binary and Gray
// write pointers, the RAM write address, and full/almost-full/level/overflow
// status computed against the synchronised read pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 1
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              W_INC,
  input  logic              W_OVF_CLR,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = depth_of(ADDR_W);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wbin_nxt;
  logic [ADDR_W:0] wgray_nxt;
  logic [ADDR_W:0] wlevel_nxt;
  logic            wfull_nxt;
  logic            walmost_full_nxt;
  logic            w_acc;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .din   (rptr_gray),
    .dout  (rq)
  );

  // Next pointer and status, folding a write and a read-pointer update together.
  always_comb begin
    w_acc            = W_INC & ~wfull;
    wbin_nxt         = wbin + PW'(w_acc);
    wgray_nxt        = PW'(bin2gray(32'(wbin_nxt)));
    rbin             = PW'(gray2bin(32'(rq), PW));
    wlevel_nxt       = wbin_nxt - rbin;
    wfull_nxt        = (wgray_nxt == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
    walmost_full_nxt = (wlevel_nxt >= PW'(DEPTH - AF_MARGIN));
  end

  // Pointer and flag registers; a blocked write leaves the pointers unchanged.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin         <= '0;
      wptr         <= '0;
      waddr        <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
    end else begin
      wbin         <= wbin_nxt;
      wptr         <= wgray_nxt;
      waddr        <= wbin_nxt[ADDR_W-1:0];
      wlevel       <= wlevel_nxt;
      wfull        <= wfull_nxt;
      walmost_full <= walmost_full_nxt;
    end
  end

  // Sticky overflow: a write attempt while full sets it and beats a same-cycle clear.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wovf <= 1'b0;
    end else if (W_INC && wfull) begin
      wovf <= 1'b1;
    end else if (W_OVF_CLR) begin
      wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed and randomised checks of fifo_wr_ctrl with ADDR_W=3,
// SYNC_STAGES=2, AF_MARGIN=2.
module tb_fifo_wr_ctrl;

  localparam int ADDR_W      = 3;
  localparam int SYNC_STAGES = 2;
  localparam int AF_MARGIN   = 2;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       W_INC = 1'b0;
  logic       W_OVF_CLR = 1'b0;
  logic [3:0] rptr_gray = 4'b0000;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       wovf;

  int total = 0;
  int bad   = 0;

  always #5 W_CLK = ~W_CLK;

  fifo_wr_ctrl #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .AF_MARGIN   (AF_MARGIN)
  ) dut (
    .W_CLK        (W_CLK),
    .W_RST        (W_RST),
    .W_INC        (W_INC),
    .W_OVF_CLR    (W_OVF_CLR),
    .rptr_gray    (rptr_gray),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  function automatic logic [3:0] toGray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] fromGray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic applyStimulus(input logic inc, input logic clr, input logic [3:0] rp);
    W_INC     = inc;
    W_OVF_CLR = clr;
    rptr_gray = rp;
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] ea, input logic [3:0] ep,
                          input logic [3:0] el, input logic ef, input logic eaf, input logic eo);
    checkOutput({tag, ".waddr"}, 32'(waddr), 32'(ea));
    checkOutput({tag, ".wptr"}, 32'(wptr), 32'(ep));
    checkOutput({tag, ".wlevel"}, 32'(wlevel), 32'(el));
    checkOutput({tag, ".wfull"}, 32'(wfull), 32'(ef));
    checkOutput({tag, ".walmost_full"}, 32'(walmost_full), 32'(eaf));
    checkOutput({tag, ".wovf"}, 32'(wovf), 32'(eo));
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expGray [8];
    logic [3:0] mbin;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] rdrv;
    logic [3:0] nbin;
    logic [3:0] mlevel;
    logic       mfull;
    logic       maf;
    logic       movf;
    logic       inc;
    logic       clr;
    logic       acc;

    expGray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Reset state
    applyStimulus(1'b0, 1'b0, 4'b0000);
    #2;
    checkAll("reset", 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    W_RST = 1'b1;

    // Eight writes fill the FIFO
    applyStimulus(1'b1, 1'b0, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkAll($sformatf("fill%0d", i), 3'(i % 8), expGray[i-1], 4'(i),
               (i == 8), (i >= 6), 1'b0);
    end

    // Writes while full are blocked and set overflow
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("blocked%0d", i), 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("ovf_set_wins", 32'(wovf), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();
    checkOutput("ovf_clear", 32'(wovf), 32'd0);

    // Read pointer moves to binary 3: flags update three edges later
    applyStimulus(1'b0, 1'b0, 4'b0010);
    tick();
    checkAll("rd_lat1", 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    tick();
    checkAll("rd_lat2", 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    tick();
    checkAll("rd_lat3", 3'd0, 4'b1100, 4'd5, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write
    applyStimulus(1'b1, 1'b0, 4'b0010);
    #2;
    W_RST = 1'b0;
    #1;
    checkAll("async_rst", 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    tick();
    W_RST = 1'b1;
    checkOutput("post_rst.waddr", 32'(waddr), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    tick();
    checkAll("post_rst_wr", 3'd1, 4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);

    // Wrap-around with the read pointer trailing by two cycles
    mbin = 4'd1;
    d1 = 4'b0000;
    d2 = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, d2);
      tick();
      mbin = mbin + 4'd1;
      checkOutput($sformatf("wrap%0d.wptr", i), 32'(wptr), 32'(toGray(mbin)));
      checkOutput($sformatf("wrap%0d.onebit", i), $countones(toGray(mbin - 4'd1) ^ wptr), 32'd1);
      checkOutput($sformatf("wrap%0d.wfull", i), 32'(wfull), 32'd0);
      d2 = d1;
      d1 = toGray(mbin);
    end

    // Randomised traffic against a cycle model
    applyStimulus(1'b0, 1'b0, 4'b0000);
    W_RST = 1'b0;
    tick();
    W_RST = 1'b1;
    mbin = '0; s1 = '0; s2 = '0; rdrv = '0;
    mfull = 1'b0; maf = 1'b0; movf = 1'b0; mlevel = '0;
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0 && mbin != rdrv) rdrv = rdrv + 4'd1;
      applyStimulus(inc, clr, toGray(rdrv));
      tick();
      acc  = inc & ~mfull;
      if (inc && mfull) movf = 1'b1;
      else if (clr) movf = 1'b0;
      nbin   = mbin + {3'b000, acc};
      mlevel = nbin - fromGray(s2);
      mfull  = (mlevel == 4'd8);
      maf    = (mlevel >= 4'd6);
      s2 = s1;
      s1 = toGray(rdrv);
      mbin = nbin;
      checkAll($sformatf("rand%0d", i), mbin[2:0], toGray(mbin), mlevel, mfull, maf, movf);
      checkOutput($sformatf("rand%0d.bound", i), 32'(wlevel <= 4'd8), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
